// File: rtl/dram_pkg.sv
// Shared types, address-field helpers and default timing for the row-buffer DRAM model.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package dram_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        REFRESH = 2'd2
    } state_t;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_ADDR_W     = 20;
    localparam int DEF_BANK_W     = 2;
    localparam int DEF_COL_W      = 8;
    localparam int DEF_T_HIT      = 1;
    localparam int DEF_T_MISS     = 4;
    localparam int DEF_REF_PERIOD = 1024;
    localparam int DEF_T_REF      = 8;

    // Word address layout is {row, bank, col}; helpers return the field right-aligned.
    function automatic logic [31:0] addr_field(input logic [31:0] addr,
                                               input int unsigned lsb,
                                               input int unsigned width);
        return (addr >> lsb) & ((32'd1 << width) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_col(input logic [31:0] addr, input int unsigned col_w);
        return addr_field(addr, 0, col_w);
    endfunction

    function automatic logic [31:0] addr_bank(input logic [31:0] addr, input int unsigned bank_w,
                                              input int unsigned col_w);
        return addr_field(addr, col_w, bank_w);
    endfunction

    function automatic logic [31:0] addr_row(input logic [31:0] addr, input int unsigned bank_w,
                                             input int unsigned col_w);
        return addr >> (bank_w + col_w);
    endfunction

endpackage

// File: rtl/dram_bank_tracker.sv
// Per-bank open-row state: combinational hit lookup, update on access completion, clear on refresh.
// Latency: lookup is combinational; updates land on the next rising edge.
// Backpressure: none; the owner sequences updates and clears.
module dram_bank_tracker
    import dram_pkg::*;
#(
    parameter int BANK_W = DEF_BANK_W,
    parameter int ROW_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BANK_W-1:0] lk_bank,
    input  logic [ROW_W-1:0]  lk_row,
    output logic              lk_hit,
    input  logic              upd_en,
    input  logic [BANK_W-1:0] upd_bank,
    input  logic [ROW_W-1:0]  upd_row,
    input  logic              clr_all
);

    localparam int NBANK = 2 ** BANK_W;

    logic [NBANK-1:0] open_vld;
    logic [ROW_W-1:0] open_row [NBANK];

    assign lk_hit = open_vld[lk_bank] && (open_row[lk_bank] == lk_row);

    // Refresh closes every bank; otherwise a completed access leaves its row open.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_vld <= '0;
            for (int b = 0; b < NBANK; b++) begin
                open_row[b] <= '0;
            end
        end else if (clr_all) begin
            open_vld <= '0;
        end else if (upd_en) begin
            open_vld[upd_bank] <= 1'b1;
            open_row[upd_bank] <= upd_row;
        end
    end

endmodule

// File: rtl/dram_rowbuf.sv
// Behavioural banked DRAM with open-row buffers, hit/miss latency and periodic refresh.
// Latency: T_HIT cycles from accept to rsp_valid on a row hit, T_MISS on a miss or closed bank.
// Backpressure: req_ready low while busy, refreshing or refresh pending; no request queue.
module dram_rowbuf
    import dram_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int BANK_W     = DEF_BANK_W,
    parameter int COL_W      = DEF_COL_W,
    parameter int T_HIT      = DEF_T_HIT,
    parameter int T_MISS     = DEF_T_MISS,
    parameter int REF_PERIOD = DEF_REF_PERIOD,
    parameter int T_REF      = DEF_T_REF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_hit
);

    localparam int ROW_W   = ADDR_W - BANK_W - COL_W;
    localparam int CNT_MAX = (T_MISS > T_REF) ? T_MISS : T_REF;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RC_W    = $clog2(REF_PERIOD);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [RC_W-1:0]   ref_cnt;
    logic              ref_pend;
    logic              ref_wrap;
    logic              done;
    logic              refresh_start;
    logic              lk_hit;

    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_hit;

    logic [BANK_W-1:0] req_bank;
    logic [ROW_W-1:0]  req_row;
    logic [BANK_W-1:0] lat_bank;
    logic [ROW_W-1:0]  lat_row;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    assign req_bank = BANK_W'(addr_bank(32'(req_addr), BANK_W, COL_W));
    assign req_row  = ROW_W'(addr_row(32'(req_addr), BANK_W, COL_W));
    assign lat_bank = BANK_W'(addr_bank(32'(lat_addr), BANK_W, COL_W));
    assign lat_row  = ROW_W'(addr_row(32'(lat_addr), BANK_W, COL_W));

    assign done          = (state == BUSY) && (cnt == '0);
    assign refresh_start = (state == IDLE) && ref_pend;
    assign ref_wrap      = (ref_cnt == RC_W'(REF_PERIOD - 1));
    // Held low during reset so nothing can be accepted while the model is cleared.
    assign req_ready     = rst_n && (state == IDLE) && !ref_pend;

    dram_bank_tracker #(
        .BANK_W (BANK_W),
        .ROW_W  (ROW_W)
    ) u_tracker (
        .clk      (clk),
        .rst_n    (rst_n),
        .lk_bank  (req_bank),
        .lk_row   (req_row),
        .lk_hit   (lk_hit),
        .upd_en   (done),
        .upd_bank (lat_bank),
        .upd_row  (lat_row),
        .clr_all  (refresh_start)
    );

    // Array commit happens only at completion, so a reset mid-access drops the write.
    always_ff @(posedge clk) begin
        if (done && lat_we) begin
            mem[lat_addr] <= lat_wdata;
        end
    end

    // Access/refresh sequencer plus the free-running refresh timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ref_cnt   <= '0;
            ref_pend  <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_hit   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_hit   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            ref_cnt   <= ref_wrap ? '0 : ref_cnt + 1'b1;
            // A wrap landing on the same edge as a refresh start re-arms the request.
            if (ref_wrap) begin
                ref_pend <= 1'b1;
            end else if (refresh_start) begin
                ref_pend <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (ref_pend) begin
                        state <= REFRESH;
                        cnt   <= CNT_W'(T_REF - 1);
                    end else if (req_valid) begin
                        state     <= BUSY;
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_hit   <= lk_hit;
                        cnt       <= lk_hit ? CNT_W'(T_HIT - 1) : CNT_W'(T_MISS - 1);
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b1;
                        rsp_hit   <= lat_hit;
                        if (!lat_we) begin
                            rsp_rdata <= mem[lat_addr];
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                REFRESH: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_rowbuf.sv
// Directed bench for dram_rowbuf: vector table for hit/miss/bank mapping plus hand-written
// sequences for reset, refresh, reset-during-write and back-to-back throughput.
// Latency is counted in rising edges from the accept edge to the edge raising rsp_valid.
module tb_dram_rowbuf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [11:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_hit;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dram_rowbuf #(
        .DATA_W(8), .ADDR_W(12), .BANK_W(2), .COL_W(4),
        .T_HIT(1), .T_MISS(4), .REF_PERIOD(64), .T_REF(3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_hit   (rsp_hit)
    );

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [7:0]  wdata;
        int          lat;
        logic        hit;
        logic        chk_rd;
        logic [7:0]  rdata;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge where rsp_valid is visible.
    task automatic access(input logic we, input logic [11:0] addr, input logic [7:0] wdata,
                          output int lat, output int waits, output logic hit,
                          output logic [7:0] rdata);
        waits = 0;
        lat   = -1;
        hit   = 1'b0;
        rdata = '0;
        while (!req_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (!req_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 20);
        if (!rsp_valid) begin
            check("rsp_timeout", 0, 1);
            lat = -1;
        end
        hit   = rsp_hit;
        rdata = rsp_rdata;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          waits;
        logic        hit;
        logic [7:0]  rd;
        bit          found;
        bit          seen;
        int          acc_cyc[4];
        logic        acc_rsp[4];
        int          nacc;
        int          nrsp;
        int          nhit;
        bit          drop;

        // bank 2 row 4 = 0x12x, bank 2 row 8 = 0x22x, bank 3 row 4 = 0x13x
        vecs[0]  = '{1'b1, 12'h123, 8'h5A, 4, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 12'h12F, 8'h00, 1, 1'b1, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 12'h123, 8'h00, 1, 1'b1, 1'b1, 8'h5A};
        vecs[3]  = '{1'b0, 12'h223, 8'h00, 4, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{1'b0, 12'h133, 8'h00, 4, 1'b0, 1'b0, 8'h00};
        vecs[5]  = '{1'b0, 12'h123, 8'h00, 4, 1'b0, 1'b1, 8'h5A};
        vecs[6]  = '{1'b0, 12'h134, 8'h00, 1, 1'b1, 1'b0, 8'h00};
        vecs[7]  = '{1'b0, 12'h123, 8'h00, 1, 1'b1, 1'b1, 8'h5A};
        vecs[8]  = '{1'b1, 12'h223, 8'hA5, 4, 1'b0, 1'b0, 8'h00};
        vecs[9]  = '{1'b0, 12'h223, 8'h00, 1, 1'b1, 1'b1, 8'hA5};
        vecs[10] = '{1'b0, 12'h123, 8'h00, 4, 1'b0, 1'b1, 8'h5A};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset state
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ready", int'(req_ready), 0);
            check("rst_rsp_valid", int'(rsp_valid), 0);
            check("rst_rdata", int'(rsp_rdata), 0);
            check("rst_hit", int'(rsp_hit), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", int'(req_ready), 1);

        // Table: miss/hit latency, bank conflicts and independent banks
        do_reset();
        for (int i = 0; i < 11; i++) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, waits, hit, rd);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_hit", i), int'(hit), int'(vecs[i].hit));
            if (vecs[i].chk_rd) begin
                check($sformatf("vec%0d_rdata", i), int'(rd), int'(vecs[i].rdata));
            end
        end

        // Refresh: hits to an open row until refresh closes it. The stall seen from a
        // response is the IDLE cycle with ref_pend set plus T_REF refresh cycles.
        do_reset();
        access(1'b0, 12'h123, 8'h00, lat, waits, hit, rd);
        check("ref_open_lat", lat, 4);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            access(1'b0, 12'h123, 8'h00, lat, waits, hit, rd);
            if (waits > 0) begin
                found = 1'b1;
                check("ref_stall", waits, 4);
                check("ref_lat", lat, 4);
                check("ref_hit", int'(hit), 0);
                check("ref_rdata", int'(rd), 8'h5A);
            end else begin
                check("pre_ref_lat", lat, 1);
            end
        end
        check("ref_found", int'(found), 1);

        // Reset during a write: no response, array keeps the old value
        do_reset();
        access(1'b1, 12'h040, 8'h11, lat, waits, hit, rd);
        check("pre_wr_lat", lat, 4);
        do_reset();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 12'h040;
        req_wdata = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_accepted", int'(req_ready), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("abort_no_rsp", int'(seen), 0);
        rst_n = 1'b1;
        access(1'b0, 12'h040, 8'h00, lat, waits, hit, rd);
        check("abort_rdata", int'(rd), 8'h11);
        check("abort_lat", lat, 4);

        // Back-to-back hits with req_valid held high
        do_reset();
        access(1'b0, 12'h123, 8'h00, lat, waits, hit, rd);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 12'h125;
        nacc = 0;
        nrsp = 0;
        nhit = 0;
        drop = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (drop) begin
                req_valid = 1'b0;
                drop = 1'b0;
            end
            if (rsp_valid) begin
                nrsp++;
                if (rsp_hit) nhit++;
            end
            if (req_valid && req_ready && nacc < 4) begin
                acc_cyc[nacc] = c;
                acc_rsp[nacc] = rsp_valid;
                nacc++;
                if (nacc == 4) drop = 1'b1;
            end
            @(negedge clk);
        end
        check("b2b_accepts", nacc, 4);
        check("b2b_rsps", nrsp, 4);
        check("b2b_hits", nhit, 4);
        for (int i = 1; i < 4; i++) begin
            if (i < nacc) begin
                check($sformatf("b2b_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], 2);
                check($sformatf("b2b_overlap%0d", i), int'(acc_rsp[i]), 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
